// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode/inc buttons edit a BCD HH:MM copy and load it into the time-of-day counter.
// Latency: edges act on the next clk; load pulses one cycle after the final mode edge.
// No backpressure: buttons are sampled every cycle, and optional alarm editing is enabled by CLOCK_SET_ALARM_EN.
module clock_set_ctrl #(
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [2:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] ld_hour1,
  output logic [3:0] ld_hour0,
  output logic [2:0] ld_min1,
  output logic [3:0] ld_min0,
  output logic       load,
  output logic       set_active,
  output logic       blank_hour,
  output logic       blank_min
`ifdef CLOCK_SET_ALARM_EN
  ,
  output logic       alarm
`endif
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    COMMIT  = 3'd3,
    AL_HR   = 3'd4,
    AL_MIN  = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic           mode_q, inc_q, armed;
  logic           mode_e, inc_e, any_edge;
  logic [5:0]     hr_q, hr_nxt;
  logic [6:0]     mn_q, mn_nxt;
  logic [IW-1:0]  idle_cnt;
  logic [BW-1:0]  blink_cnt;
  logic           blink_off;
  logic           idle_hit;
  logic           set_state;
  logic           state_chg;
  logic           run_go;

`ifdef CLOCK_SET_ALARM_EN
  logic [5:0]     al_hr_q, al_hr_nxt;
  logic [6:0]     al_mn_q, al_mn_nxt;
  logic           alarm_q;
  logic           match_q;
  logic           al_match;
`endif

  // BCD hour step 00..23 with wrap; hour0 carries into hour1 after 9.
  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    logic [1:0] h1;
    logic [3:0] h0;
    h1 = h[5:4];
    h0 = h[3:0];
    if (h1 == 2'd2 && h0 == 4'd3) begin
      h1 = 2'd0;
      h0 = 4'd0;
    end else if (h0 == 4'd9) begin
      h0 = 4'd0;
      h1 = h1 + 2'd1;
    end else begin
      h0 = h0 + 4'd1;
    end
    return {h1, h0};
  endfunction

  // BCD minute step 00..59 with wrap.
  function automatic logic [6:0] min_inc(input logic [6:0] m);
    logic [2:0] m1;
    logic [3:0] m0;
    m1 = m[6:4];
    m0 = m[3:0];
    if (m0 == 4'd9) begin
      m0 = 4'd0;
      m1 = (m1 == 3'd5) ? 3'd0 : m1 + 3'd1;
    end else begin
      m0 = m0 + 4'd1;
    end
    return {m1, m0};
  endfunction

  // Edges are suppressed on the first clock after reset so a held button is not seen as a press.
  assign mode_e   = armed & mode_btn & ~mode_q;
  assign inc_e    = armed & inc_btn & ~inc_q;
  assign any_edge = mode_e | inc_e;
  assign idle_hit = (idle_cnt == IW'(TIMEOUT_CYC - 1));
  assign state_chg = (state_nxt != state);

`ifdef CLOCK_SET_ALARM_EN
  // A mode press while the alarm rings only silences it.
  assign run_go    = mode_e & ~alarm_q;
  assign set_state = (state == SET_HR) | (state == SET_MIN) |
                     (state == AL_HR)  | (state == AL_MIN);
  assign al_match  = ({cur_hour1, cur_hour0, cur_min1, cur_min0} == {al_hr_q, al_mn_q}) & ~set_state;
  assign alarm     = alarm_q;
`else
  assign run_go    = mode_e;
  assign set_state = (state == SET_HR) | (state == SET_MIN);
`endif

  // Next state and edit-register updates; mode edges take priority over inc, edges over timeout.
  always_comb begin
    state_nxt = state;
    hr_nxt    = hr_q;
    mn_nxt    = mn_q;
`ifdef CLOCK_SET_ALARM_EN
    al_hr_nxt = al_hr_q;
    al_mn_nxt = al_mn_q;
`endif
    case (state)
      RUN: begin
        if (run_go) begin
          hr_nxt    = {cur_hour1, cur_hour0};
          mn_nxt    = {cur_min1, cur_min0};
          state_nxt = SET_HR;
        end
      end
      SET_HR: begin
        if (mode_e)        state_nxt = SET_MIN;
        else if (inc_e)    hr_nxt    = hour_inc(hr_q);
        else if (idle_hit) state_nxt = RUN;
      end
      SET_MIN: begin
        if (mode_e)        state_nxt = COMMIT;
        else if (inc_e)    mn_nxt    = min_inc(mn_q);
        else if (idle_hit) state_nxt = RUN;
      end
      COMMIT: begin
`ifdef CLOCK_SET_ALARM_EN
        state_nxt = AL_HR;
`else
        state_nxt = RUN;
`endif
      end
`ifdef CLOCK_SET_ALARM_EN
      AL_HR: begin
        if (mode_e)        state_nxt = AL_MIN;
        else if (inc_e)    al_hr_nxt = hour_inc(al_hr_q);
        else if (idle_hit) state_nxt = RUN;
      end
      AL_MIN: begin
        if (mode_e)        state_nxt = RUN;
        else if (inc_e)    al_mn_nxt = min_inc(al_mn_q);
        else if (idle_hit) state_nxt = RUN;
      end
`endif
      default: state_nxt = RUN;
    endcase
  end

  // State and edit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      hr_q  <= '0;
      mn_q  <= '0;
    end else begin
      state <= state_nxt;
      hr_q  <= hr_nxt;
      mn_q  <= mn_nxt;
    end
  end

  // Previous button levels for edge detection, plus the post-reset arming flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      mode_q <= mode_btn;
      inc_q  <= inc_btn;
      armed  <= 1'b1;
    end
  end

  // Idle counter: restarts on any edge or state change, counts only while editing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state_chg || any_edge || !set_state) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Blink divider: restarts visible on every state change, toggles phase every BLINK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (state_chg || !set_state) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

`ifdef CLOCK_SET_ALARM_EN
  // Alarm registers and ring flag; the flag fires once when the live time first matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_hr_q <= '0;
      al_mn_q <= '0;
      match_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      al_hr_q <= al_hr_nxt;
      al_mn_q <= al_mn_nxt;
      match_q <= al_match;
      if (state == RUN && mode_e)    alarm_q <= 1'b0;
      else if (al_match && !match_q) alarm_q <= 1'b1;
    end
  end

  assign blank_hour = blink_off & ((state == SET_HR)  | (state == AL_HR));
  assign blank_min  = blink_off & ((state == SET_MIN) | (state == AL_MIN));
`else
  assign blank_hour = blink_off & (state == SET_HR);
  assign blank_min  = blink_off & (state == SET_MIN);
`endif

  assign load       = (state == COMMIT);
  assign set_active = set_state;
  assign ld_hour1   = hr_q[5:4];
  assign ld_hour0   = hr_q[3:0];
  assign ld_min1    = mn_q[6:4];
  assign ld_min0    = mn_q[3:0];

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (0.5 s at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 500000000, idle clk cycles in any set state before abort (10 s).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, 20 ns period.
REQ-004 SHALL have port rst  input  1  reset; one clock domain, reset asynchronous and active-high.
REQ-005 SHALL have port mode_btn  input  1  debounced, synchronous level; the rising edge advances the state.
REQ-006 SHALL have port inc_btn  input  1  debounced, synchronous level; the rising edge increments the edited field.
REQ-007 SHALL have ports cur_hour1 (2), cur_hour0 (4), cur_min1 (3) and cur_min0 (4), all inputs, giving the live BCD time from the time-of-day counter.
REQ-008 SHALL have ports ld_hour1 (2), ld_hour0 (4), ld_min1 (3) and ld_min0 (4), all outputs, giving the BCD value to load into the counter.
REQ-009 SHALL have port load  output  1  one-cycle pulse; the counter takes ld_* on this cycle.
REQ-010 SHALL have port set_active  output  1  high in any set state; the counter freezes while it is high.
REQ-011 SHALL have port blank_hour  output  1  blanks the hour digits during the blink-off phase.
REQ-012 SHALL have port blank_min  output  1  blanks the minute digits during the blink-off phase.

Function
REQ-013 SHALL implement FSM states RUN, SET_HR, SET_MIN and COMMIT.
REQ-014 SHALL detect button edges by comparing each button with its registered previous value; a held button produces one edge only.
REQ-015 SHALL, on a mode edge in RUN, copy cur_* into the edit registers and enter SET_HR on the next cycle.
REQ-016 SHALL, on an inc edge in SET_HR, step the hour through BCD 00..23 and wrap from 23 to 00; hour0 wraps from 9 to 0 with carry into hour1.
REQ-017 SHALL, on an inc edge in SET_MIN, step the minute through BCD 00..59 and wrap from 59 to 00; the hour is unaffected.
REQ-018 SHALL make a mode edge move SET_HR to SET_MIN and SET_MIN to COMMIT.
REQ-019 SHALL, in COMMIT, assert load for exactly one cycle with ld_* equal to the edit registers, then return to RUN.
REQ-020 SHALL keep ld_* driven from the edit registers at all times; they are valid only while load is high.
REQ-021 SHALL, when a mode edge and an inc edge arrive in the same cycle, take the mode edge and discard the inc edge.
REQ-022 SHALL ignore inc edges in RUN and COMMIT.
REQ-023 SHALL restart the idle counter on any edge; reaching TIMEOUT_CYC-1 in SET_HR or SET_MIN SHALL return to RUN with no load pulse.
REQ-024 SHALL run the blink counter only in set states and clear it to 0 on each state change, with the phase starting visible.
REQ-025 SHALL, in SET_HR, drive blank_hour from the blink-off phase and hold blank_min at 0; SET_MIN is symmetric; both are 0 in all other states.
REQ-026 SHALL make set_active equal 1 in SET_HR and SET_MIN and 0 in RUN and COMMIT.

Reset
REQ-027 SHALL, while rst is high, force state RUN, edit registers 00:00, load=0, set_active=0, blank_*=0, all counters 0 and edge registers 0, independent of clk.
REQ-028 SHALL, when rst is asserted mid-edit, discard the edit and produce no load pulse.
REQ-029 SHALL ignore a button held high at reset release, because the edge registers come out of reset at 0 and take the button level on the first clock.

Configuration
REQ-030 SHALL, when CLOCK_SET_ALARM_EN is defined, add states AL_HR and AL_MIN after COMMIT (COMMIT -> AL_HR -> AL_MIN -> RUN on mode edges), with the same increment, wrap, blink and timeout rules, editing alarm registers that reset to 00:00.
REQ-031 SHALL, when CLOCK_SET_ALARM_EN is defined, add output alarm (1), which goes high on the cycle cur_* equals the alarm registers while set_active=0 and clears on a mode edge in RUN; that mode edge only clears the alarm and does not enter SET_HR.
REQ-032 SHALL, when CLOCK_SET_ALARM_EN is undefined, omit the alarm port and states, and make COMMIT return directly to RUN.

Verification
REQ-033 SHALL cover: cur=12:34, then mode, mode, mode edges -> one load pulse with ld=12:34 and the state back in RUN.
REQ-034 SHALL cover: in SET_HR from 22, two inc edges -> hour 23 then 00, hour1=0.
REQ-035 SHALL cover: in SET_MIN from 58, two inc edges -> 59 then 00, hour unchanged.
REQ-036 SHALL cover: mode and inc rising in the same cycle in SET_HR -> state SET_MIN and hour unchanged.
REQ-037 SHALL cover: TIMEOUT_CYC=100 with no edges in SET_MIN -> RUN after 100 cycles, no load pulse, set_active=0.
REQ-038 SHALL cover: rst pulsed asynchronously mid-SET_MIN -> outputs at reset values before the next clk edge, and no load pulse.
